// File: rtl/array_eyeriss_bserial_pkg.sv
// Shared types and width helpers for the bit-serial Eyeriss-style PE array.
package array_eyeriss_bserial_pkg;

  // Job sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MAC   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Width of the step counter / cfg_k port for a given maximum step count.
  function automatic int kw_f(input int kmax);
    return $clog2(kmax + 1);
  endfunction

  // Width of the serial bit counter (at least one bit).
  function automatic int bw_f(input int iwidth);
    return (iwidth > 1) ? $clog2(iwidth) : 1;
  endfunction

  // Width of the drain row index (at least one bit).
  function automatic int rw_f(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/array_eyeriss_bserial_if.sv
// Control, operand-in and result-out signals of the PE array.
interface array_eyeriss_bserial_if #(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 24,
  parameter int KMAX   = 255
);
  import array_eyeriss_bserial_pkg::*;

  localparam int KW = kw_f(KMAX);
  localparam int RW = rw_f(HEIGHT);

  // job control
  logic                                  start;
  logic [KW-1:0]                         cfg_k;
  logic                                  busy;
  logic                                  done;
  // operand stream
  logic                                  in_valid;
  logic                                  in_ready;
  logic signed [HEIGHT-1:0][IWIDTH-1:0]  ifm;
  logic signed [WIDTH-1:0][IWIDTH-1:0]   wght;
  // result stream
  logic                                  out_valid;
  logic                                  out_ready;
  logic [RW-1:0]                         out_row;
  logic signed [WIDTH-1:0][OWIDTH-1:0]   ofm;

  // Producer/consumer side.
  modport master (
    output start, cfg_k, in_valid, ifm, wght, out_ready,
    input  busy, done, in_ready, out_valid, out_row, ofm
  );

  // Array side.
  modport slave (
    input  start, cfg_k, in_valid, ifm, wght, out_ready,
    output busy, done, in_ready, out_valid, out_row, ofm
  );

endinterface

// File: rtl/array_eyeriss_bserial_pe_bserial.sv
// One processing element: serial two's-complement multiply-accumulate.
module pe_bserial #(
  parameter int OWIDTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,   // zero the accumulator (job start)
  input  logic              en,    // a MAC bit-cycle is active
  input  logic              sub,   // sign bit of the weight: subtract
  input  logic              wbit,  // current weight bit of this column
  input  logic [OWIDTH-1:0] op,    // row operand, sign-extended and shifted
  output logic [OWIDTH-1:0] acc
);

  logic [OWIDTH-1:0] acc_q;
  logic [OWIDTH-1:0] acc_d;

  // Next accumulator value: add/subtract the shifted row operand when the weight bit is set.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en && wbit) begin
      acc_d = sub ? (acc_q - op) : (acc_q + op);
    end
  end

  // Accumulator register; wraps modulo 2^OWIDTH.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/array_eyeriss_bserial.sv
// HEIGHT x WIDTH bit-serial MAC array: ifm multicast along rows, weight bits
// multicast down columns, one weight bit per cycle, results drained row by row.
module array_eyeriss_bserial
  import array_eyeriss_bserial_pkg::*;
#(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 24,
  parameter int KMAX   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  array_eyeriss_bserial_if.slave bus
);

  localparam int KW = kw_f(KMAX);
  localparam int BW = bw_f(IWIDTH);
  localparam int RW = rw_f(HEIGHT);

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [KW-1:0]            count_q, count_d;
  logic [BW-1:0]            b_q, b_d;
  logic [HEIGHT-1:0][IWIDTH-1:0] ifm_q, ifm_d;
  logic [WIDTH-1:0][IWIDTH-1:0]  wght_q, wght_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [RW-1:0]            row_q, row_d;

  logic [KW-1:0]            cfg_k_clamped;
  logic [KW-1:0]            count_inc;
  logic                     clr;
  logic                     mac_en;
  logic                     mac_last;
  logic [OWIDTH-1:0]        row_op  [HEIGHT];
  logic                     col_bit [WIDTH];
  logic [OWIDTH-1:0]        acc     [HEIGHT][WIDTH];
  logic [WIDTH-1:0][OWIDTH-1:0] ofm_mux;

  assign cfg_k_clamped = (bus.cfg_k > KW'(KMAX)) ? KW'(KMAX) : bus.cfg_k;
  assign count_inc     = count_q + 1'b1;
  assign clr           = (state_q == S_IDLE) && bus.start;
  assign mac_en        = (state_q == S_MAC);
  assign mac_last      = (b_q == BW'(IWIDTH - 1));

  // Row operands: sign-extend the latched ifm and weight it by 2^b.
  generate
    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row
      assign row_op[gi] = {{(OWIDTH-IWIDTH){ifm_q[gi][IWIDTH-1]}}, ifm_q[gi]} << b_q;
    end
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
      assign col_bit[gi] = wght_q[gi][b_q];
    end
    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_pe_row
      for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pe_col
        pe_bserial #(.OWIDTH(OWIDTH)) u_pe (
          .clk  (clk),
          .rst  (rst),
          .clr  (clr),
          .en   (mac_en),
          .sub  (mac_last),
          .wbit (col_bit[gj]),
          .op   (row_op[gi]),
          .acc  (acc[gi][gj])
        );
      end
    end
  endgenerate

  // Next-state logic for the job FSM, counters, operand latches and outputs.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    count_d     = count_q;
    b_d         = b_q;
    ifm_d       = ifm_q;
    wght_d      = wght_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    row_d       = row_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          k_d     = cfg_k_clamped;
          count_d = '0;
          b_d     = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          if (cfg_k_clamped == '0) begin
            state_d     = S_DRAIN;
            out_valid_d = 1'b1;
          end else begin
            state_d    = S_LOAD;
            in_ready_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          ifm_d      = bus.ifm;
          wght_d     = bus.wght;
          b_d        = '0;
          in_ready_d = 1'b0;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        if (mac_last) begin
          b_d     = '0;
          count_d = count_inc;
          if (count_inc == k_q) begin
            state_d     = S_DRAIN;
            out_valid_d = 1'b1;
            row_d       = '0;
          end else begin
            state_d    = S_LOAD;
            in_ready_d = 1'b1;
          end
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == RW'(HEIGHT - 1)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            row_d       = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      count_q     <= '0;
      b_q         <= '0;
      ifm_q       <= '0;
      wght_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      count_q     <= count_d;
      b_q         <= b_d;
      ifm_q       <= ifm_d;
      wght_q      <= wght_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      row_q       <= row_d;
    end
  end

  // Drain mux: the selected row's accumulators, zero when nothing is offered.
  always_comb begin
    ofm_mux = '0;
    if (out_valid_q) begin
      for (int w = 0; w < WIDTH; w++) ofm_mux[w] = acc[row_q][w];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = row_q;
  assign bus.ofm       = ofm_mux;

endmodule

// File: tb/tb_array_eyeriss_bserial.sv
// Scoreboard bench for array_eyeriss_bserial: a product-sum model predicts each
// drained row; observed rows are collected and popped against it.
module tb_array_eyeriss_bserial;
  import array_eyeriss_bserial_pkg::*;

  localparam int HEIGHT = 4;
  localparam int WIDTH  = 4;
  localparam int IWIDTH = 8;
  localparam int OWIDTH = 24;
  localparam int KMAX   = 255;
  localparam int KW     = kw_f(KMAX);

  typedef logic signed [HEIGHT-1:0][IWIDTH-1:0] ifm_t;
  typedef logic signed [WIDTH-1:0][IWIDTH-1:0]  wght_t;
  typedef logic signed [WIDTH-1:0][OWIDTH-1:0]  ofm_t;
  typedef struct {
    int   row;
    ofm_t vals;
  } row_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_eyeriss_bserial_if #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .KMAX(KMAX)
  ) bus ();

  array_eyeriss_bserial #(
    .HEIGHT(HEIGHT), .WIDTH(WIDTH), .IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .KMAX(KMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int       tests_run    = 0;
  int       tests_failed = 0;
  longint   model [HEIGHT][WIDTH];
  row_rec_t sb_q[$];
  row_rec_t obs_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w++) model[h][w] = 0;
  endtask

  task automatic model_step(input ifm_t a, input wght_t b);
    for (int h = 0; h < HEIGHT; h++)
      for (int w = 0; w < WIDTH; w++)
        model[h][w] += longint'($signed(a[h])) * longint'($signed(b[w]));
  endtask

  // Push the predicted drain rows of the finished job.
  task automatic model_push();
    row_rec_t rec;
    for (int h = 0; h < HEIGHT; h++) begin
      rec.row = h;
      for (int w = 0; w < WIDTH; w++) rec.vals[w] = OWIDTH'(model[h][w]);
      sb_q.push_back(rec);
    end
  endtask

  task automatic start_job(input int k);
    bus.cfg_k = KW'(k);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    model_clear();
  endtask

  // Offer one operand vector; lat = cycles from handshake until in_ready or out_valid.
  task automatic send_step(input ifm_t a, input wght_t b, output int lat);
    int guard;
    bus.ifm      = a;
    bus.wght     = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!bus.in_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL in_ready_timeout got in_ready=%0b want 1", bus.in_ready);
      bus.in_valid = 1'b0;
      lat = -1;
      return;
    end
    tick();
    bus.in_valid = 1'b0;
    model_step(a, b);
    lat = 0;
    while (!bus.in_ready && !bus.out_valid && lat < 50) begin
      lat++;
      tick();
    end
  endtask

  // Accept HEIGHT rows with out_ready held high, recording them; count done pulses.
  task automatic drain_all(output int ndone);
    row_rec_t rec;
    int n;
    int guard;
    n = 0;
    guard = 0;
    ndone = 0;
    bus.out_ready = 1'b1;
    while (n < HEIGHT && guard < 200) begin
      if (bus.done) ndone++;
      if (bus.out_valid) begin
        rec.row  = int'(bus.out_row);
        rec.vals = bus.ofm;
        obs_q.push_back(rec);
        $display("[TB] drain row=%0d ofm=%h", rec.row, rec.vals);
        n++;
      end
      tick();
      guard++;
    end
    bus.out_ready = 1'b0;
    repeat (4) begin
      if (bus.done) ndone++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    tests_run++;
    if (bus.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready got %b want 0", bus.in_ready); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests_run++;
    if (bus.out_row !== '0) begin tests_failed++; $display("[TB] FAIL reset_out_row got %0d want 0", bus.out_row); end
    tests_run++;
    if (bus.ofm !== '0) begin tests_failed++; $display("[TB] FAIL reset_ofm got %h want 0", bus.ofm); end
    rst = 1'b0;
    tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    ifm_t a;
    wght_t b;
    int lat;
    int nd;
    row_rec_t e;
    row_rec_t g;
    for (int h = 0; h < HEIGHT; h++) a[h] = 8'sd3;
    for (int w = 0; w < WIDTH; w++)  b[w] = 8'sd5;
    start_job(1);
    send_step(a, b, lat);
    tests_run++;
    if (lat !== IWIDTH) begin tests_failed++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, IWIDTH); end
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_drain_entry got in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
    end
    model_push();
    drain_all(nd);
    tests_run++;
    if (obs_q.size() != sb_q.size()) begin tests_failed++; $display("[TB] FAIL basic_rows got %0d want %0d", obs_q.size(), sb_q.size()); end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = obs_q.pop_front();
      tests_run++;
      if (g.row !== e.row || g.vals !== e.vals) begin
        tests_failed++;
        $display("[TB] FAIL basic_row got row=%0d ofm=%h want row=%0d ofm=%h", g.row, g.vals, e.row, e.vals);
      end
    end
    sb_q.delete(); obs_q.delete();
    tests_run++;
    if (nd !== 1) begin tests_failed++; $display("[TB] FAIL basic_done_count got %0d want 1", nd); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_signed();
    ifm_t a;
    wght_t b;
    int lat;
    int nd;
    row_rec_t e;
    row_rec_t g;
    a = '0;
    b = '0;
    a[0] = -8'sd128; b[0] = -8'sd128;
    a[1] = 8'sd127;  b[1] = -8'sd1;
    a[2] = -8'sd7;   b[2] = 8'sd100;
    start_job(1);
    send_step(a, b, lat);
    model_push();
    drain_all(nd);
    tests_run++;
    if (obs_q.size() != sb_q.size()) begin tests_failed++; $display("[TB] FAIL signed_rows got %0d want %0d", obs_q.size(), sb_q.size()); end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = obs_q.pop_front();
      tests_run++;
      if (g.row !== e.row || g.vals !== e.vals) begin
        tests_failed++;
        $display("[TB] FAIL signed_row got row=%0d ofm=%h want row=%0d ofm=%h", g.row, g.vals, e.row, e.vals);
      end
    end
    sb_q.delete(); obs_q.delete();
    tests_run++;
    if (nd !== 1) begin tests_failed++; $display("[TB] FAIL signed_done_count got %0d want 1", nd); end
  endtask

  task automatic test_multi();
    ifm_t a;
    wght_t b;
    int lat;
    int nd;
    row_rec_t e;
    row_rec_t g;
    for (int h = 0; h < HEIGHT; h++) a[h] = IWIDTH'(h + 1);
    for (int w = 0; w < WIDTH; w++)  b[w] = IWIDTH'(w + 1);
    start_job(4);
    for (int s = 0; s < 4; s++) begin
      send_step(a, b, lat);
      tests_run++;
      if (lat !== IWIDTH) begin tests_failed++; $display("[TB] FAIL multi_latency step=%0d got %0d want %0d", s, lat, IWIDTH); end
      $display("[TB] multi step=%0d latency=%0d", s, lat);
    end
    model_push();
    drain_all(nd);
    tests_run++;
    if (obs_q.size() != sb_q.size()) begin tests_failed++; $display("[TB] FAIL multi_rows got %0d want %0d", obs_q.size(), sb_q.size()); end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = obs_q.pop_front();
      tests_run++;
      if (g.row !== e.row || g.vals !== e.vals) begin
        tests_failed++;
        $display("[TB] FAIL multi_row got row=%0d ofm=%h want row=%0d ofm=%h", g.row, g.vals, e.row, e.vals);
      end
    end
    sb_q.delete(); obs_q.delete();
    tests_run++;
    if (nd !== 1) begin tests_failed++; $display("[TB] FAIL multi_done_count got %0d want 1", nd); end
  endtask

  task automatic test_backpressure();
    ifm_t a;
    wght_t b;
    int lat;
    int nd;
    int n;
    int guard;
    ofm_t hold;
    row_rec_t rec;
    row_rec_t e;
    row_rec_t g;
    for (int h = 0; h < HEIGHT; h++) a[h] = IWIDTH'($urandom_range(0, 255));
    for (int w = 0; w < WIDTH; w++)  b[w] = IWIDTH'($urandom_range(0, 255));
    start_job(1);
    send_step(a, b, lat);
    model_push();
    n = 0;
    nd = 0;
    bus.out_ready = 1'b1;
    // row 0 is accepted immediately
    if (bus.out_valid) begin
      rec.row = int'(bus.out_row); rec.vals = bus.ofm; obs_q.push_back(rec); n++;
    end
    tick();
    bus.out_ready = 1'b0;
    hold = bus.ofm;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.out_row !== 2'd1 || bus.ofm !== hold || bus.out_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold cycle=%0d got row=%0d ofm=%h valid=%b want row=1 ofm=%h valid=1",
                 i, bus.out_row, bus.ofm, bus.out_valid, hold);
      end
      $display("[TB] stall cycle=%0d row=%0d ofm=%h", i, bus.out_row, bus.ofm);
      tick();
    end
    bus.out_ready = 1'b1;
    guard = 0;
    while (n < HEIGHT && guard < 50) begin
      if (bus.out_valid) begin
        rec.row = int'(bus.out_row); rec.vals = bus.ofm; obs_q.push_back(rec); n++;
      end
      tick();
      guard++;
    end
    bus.out_ready = 1'b0;
    repeat (4) begin
      if (bus.done) nd++;
      tick();
    end
    tests_run++;
    if (obs_q.size() != sb_q.size()) begin tests_failed++; $display("[TB] FAIL stall_rows got %0d want %0d", obs_q.size(), sb_q.size()); end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = obs_q.pop_front();
      tests_run++;
      if (g.row !== e.row || g.vals !== e.vals) begin
        tests_failed++;
        $display("[TB] FAIL stall_row got row=%0d ofm=%h want row=%0d ofm=%h", g.row, g.vals, e.row, e.vals);
      end
    end
    sb_q.delete(); obs_q.delete();
    tests_run++;
    if (nd !== 1) begin tests_failed++; $display("[TB] FAIL stall_done_count got %0d want 1", nd); end
  endtask

  task automatic test_abort();
    ifm_t a;
    wght_t b;
    int lat;
    int nd;
    int guard;
    row_rec_t e;
    row_rec_t g;
    for (int h = 0; h < HEIGHT; h++) a[h] = 8'sd7;
    for (int w = 0; w < WIDTH; w++)  b[w] = 8'sd9;
    start_job(1);
    bus.ifm = a;
    bus.wght = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin tick(); guard++; end
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();    // now in MAC bit 4
    rst = 1'b1;
    tick();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.ofm !== '0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state got busy=%b in_ready=%b out_valid=%b done=%b ofm=%h want all 0",
               bus.busy, bus.in_ready, bus.out_valid, bus.done, bus.ofm);
    end
    rst = 1'b0;
    nd = 0;
    repeat (4) begin
      if (bus.done) nd++;
      tick();
    end
    tests_run++;
    if (nd !== 0) begin tests_failed++; $display("[TB] FAIL abort_no_done got %0d want 0", nd); end
    $display("[TB] abort checked");
    for (int h = 0; h < HEIGHT; h++) a[h] = 8'sd2;
    for (int w = 0; w < WIDTH; w++)  b[w] = 8'sd2;
    start_job(1);
    send_step(a, b, lat);
    model_push();
    drain_all(nd);
    tests_run++;
    if (obs_q.size() != sb_q.size()) begin tests_failed++; $display("[TB] FAIL abort_rows got %0d want %0d", obs_q.size(), sb_q.size()); end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = obs_q.pop_front();
      tests_run++;
      if (g.row !== e.row || g.vals !== e.vals) begin
        tests_failed++;
        $display("[TB] FAIL abort_rerun_row got row=%0d ofm=%h want row=%0d ofm=%h", g.row, g.vals, e.row, e.vals);
      end
    end
    sb_q.delete(); obs_q.delete();
    tests_run++;
    if (nd !== 1) begin tests_failed++; $display("[TB] FAIL abort_rerun_done got %0d want 1", nd); end
  endtask

  task automatic test_zero_k();
    int nd;
    row_rec_t e;
    row_rec_t g;
    start_job(0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out_row !== '0 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_k_entry got valid=%b busy=%b row=%0d in_ready=%b want 1 1 0 0",
               bus.out_valid, bus.busy, bus.out_row, bus.in_ready);
    end
    // start and in_valid while draining must both be ignored
    bus.cfg_k    = KW'(1);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.ifm      = '1;
    bus.wght     = '1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_row !== '0 || bus.in_ready !== 1'b0 || bus.ofm !== '0) begin
      tests_failed++;
      $display("[TB] FAIL zero_k_restart got valid=%b row=%0d in_ready=%b ofm=%h want 1 0 0 0",
               bus.out_valid, bus.out_row, bus.in_ready, bus.ofm);
    end
    model_push();
    drain_all(nd);
    tests_run++;
    if (obs_q.size() != sb_q.size()) begin tests_failed++; $display("[TB] FAIL zero_k_rows got %0d want %0d", obs_q.size(), sb_q.size()); end
    while (obs_q.size() > 0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = obs_q.pop_front();
      tests_run++;
      if (g.row !== e.row || g.vals !== e.vals) begin
        tests_failed++;
        $display("[TB] FAIL zero_k_row got row=%0d ofm=%h want row=%0d ofm=%h", g.row, g.vals, e.row, e.vals);
      end
    end
    sb_q.delete(); obs_q.delete();
    tests_run++;
    if (nd !== 1) begin tests_failed++; $display("[TB] FAIL zero_k_done got %0d want 1", nd); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_k_idle got busy=%b want 0", bus.busy); end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.cfg_k     = '0;
    bus.in_valid  = 1'b0;
    bus.ifm       = '0;
    bus.wght      = '0;
    bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_signed();
    test_multi();
    test_backpressure();
    test_abort();
    test_zero_k();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
